// File: rtl/apb_xfer_scheduler.sv
// Burst scheduler between the AXI read/write front-ends and the APB master:
// round-robin arbitration, FIFO gating, command/status handshake, error collection.
//
// state     | meaning
// S_IDLE    | no burst owned; arbitrate eligible requests
// S_ISSUE   | READ/WRITE command held until the master reports BUSY
// S_RUN     | master moving beats; accumulate pslverr until SWITCH
// S_RELEASE | one cycle of DISABLE plus the done pulse
module apb_xfer_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic [3:0]       rd_len,
    input  logic [CNT_W-1:0] rd_fifo_free,
    input  logic             wr_req,
    input  logic [3:0]       wr_len,
    input  logic [CNT_W-1:0] wr_fifo_count,
    output logic [1:0]       apb_cmd,
    input  logic [1:0]       apb_info,
    input  logic             penable,
    input  logic             pready,
    input  logic             pslverr,
    output logic             rd_grant,
    output logic             wr_grant,
    output logic             rd_done,
    output logic             wr_done,
    output logic             xfer_err,
    output logic             busy
);

    localparam int NW = CNT_W + 1;

    localparam logic [1:0] CMD_IDLE    = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_DISABLE = 2'b11;

    localparam logic [1:0] INFO_BUSY   = 2'b01;
    localparam logic [1:0] INFO_SWITCH = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_RUN     = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    state_t state, state_nxt;
    logic   sel, sel_nxt;             // 1 = write burst owns the master
    logic   last_grant, last_grant_nxt;
    logic   err_acc, err_acc_nxt;

    logic [NW-1:0] rd_need, wr_need;
    logic          rd_ok, wr_ok;
    logic          beat_err;

    // One extra bit keeps len=15 (16 beats) from wrapping.
    assign rd_need  = NW'(rd_len) + NW'(1);
    assign wr_need  = NW'(wr_len) + NW'(1);
    assign rd_ok    = rd_req && ({1'b0, rd_fifo_free} >= rd_need);
    assign wr_ok    = wr_req && ({1'b0, wr_fifo_count} >= wr_need);
    assign beat_err = penable && pready && pslverr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            err_acc    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
            err_acc    <= err_acc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        err_acc_nxt    = err_acc;
        apb_cmd        = CMD_IDLE;
        rd_grant       = 1'b0;
        wr_grant       = 1'b0;
        rd_done        = 1'b0;
        wr_done        = 1'b0;
        xfer_err       = 1'b0;
        busy           = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (rd_ok || wr_ok) begin
                    sel_nxt     = (rd_ok && wr_ok) ? ~last_grant : wr_ok;
                    err_acc_nxt = 1'b0;
                    state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                apb_cmd  = sel ? CMD_WRITE : CMD_READ;
                rd_grant = ~sel;
                wr_grant = sel;
                // A SWITCH here means BUSY was too short to be seen.
                if (apb_info == INFO_BUSY) begin
                    state_nxt = S_RUN;
                end else if (apb_info == INFO_SWITCH) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RUN: begin
                rd_grant = ~sel;
                wr_grant = sel;
                if (beat_err) begin
                    err_acc_nxt = 1'b1;
                end
                if (apb_info == INFO_SWITCH) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                apb_cmd        = CMD_DISABLE;
                rd_grant       = ~sel;
                wr_grant       = sel;
                rd_done        = ~sel;
                wr_done        = sel;
                xfer_err       = err_acc | beat_err;
                last_grant_nxt = sel;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_xfer_scheduler.sv
// Bench for apb_xfer_scheduler: eligibility vector table, directed multi-cycle
// sequences, and randomized bursts checked against a transaction-level model.
module tb_apb_xfer_scheduler;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rd_req = 1'b0;
    logic [3:0]       rd_len = '0;
    logic [CNT_W-1:0] rd_fifo_free = '0;
    logic             wr_req = 1'b0;
    logic [3:0]       wr_len = '0;
    logic [CNT_W-1:0] wr_fifo_count = '0;
    logic [1:0]       apb_cmd;
    logic [1:0]       apb_info = 2'b00;
    logic             penable = 1'b0;
    logic             pready = 1'b0;
    logic             pslverr = 1'b0;
    logic             rd_grant, wr_grant, rd_done, wr_done, xfer_err, busy;

    int total = 0;
    int bad = 0;

    apb_xfer_scheduler #(.FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_len(rd_len), .rd_fifo_free(rd_fifo_free),
        .wr_req(wr_req), .wr_len(wr_len), .wr_fifo_count(wr_fifo_count),
        .apb_cmd(apb_cmd), .apb_info(apb_info),
        .penable(penable), .pready(pready), .pslverr(pslverr),
        .rd_grant(rd_grant), .wr_grant(wr_grant),
        .rd_done(rd_done), .wr_done(wr_done),
        .xfer_err(xfer_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rq;
        int         rl;
        int         rf;
        logic       wq;
        int         wl;
        int         wc;
        logic [1:0] cmd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_apb();
        apb_info = 2'b00;
        penable  = 1'b0;
        pready   = 1'b0;
        pslverr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        idle_apb();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input logic rq, input int rl, input int rf,
                           input logic wq, input int wl, input int wc);
        rd_req        = rq;
        rd_len        = 4'(rl);
        rd_fifo_free  = CNT_W'(rf);
        wr_req        = wq;
        wr_len        = 4'(wl);
        wr_fifo_count = CNT_W'(wc);
    endtask

    // Called in the first cycle the command should be on the bus; acts as the
    // APB master for the whole burst and ends back in the idle cycle.
    task automatic do_burst(input bit is_wr, input int len, input logic [15:0] errs,
                            input bit rel_err, input int delay);
        logic [1:0] ec;
        bit exp_err;
        ec = is_wr ? 2'b10 : 2'b01;
        exp_err = rel_err;
        chk("issue_cmd", apb_cmd, ec);
        chk("issue_rd_grant", rd_grant, !is_wr);
        chk("issue_wr_grant", wr_grant, is_wr);
        chk("issue_busy", busy, 1);
        for (int i = 0; i < delay; i++) begin
            apb_info = ($urandom % 2) ? 2'b11 : 2'b00;
            step();
            chk("hold_cmd", apb_cmd, ec);
        end
        apb_info = 2'b01;
        step();
        chk("run_cmd", apb_cmd, 0);
        for (int b = 0; b <= len; b++) begin
            penable = 1'b1;
            pready  = 1'b0;
            pslverr = 1'($urandom % 2);
            step();
            pready  = 1'b1;
            pslverr = errs[b];
            exp_err = exp_err | errs[b];
            step();
            chk("run_no_done", {30'd0, rd_done, wr_done}, 0);
            chk("run_grant", {30'd0, rd_grant, wr_grant}, is_wr ? 1 : 2);
            penable = 1'b0;
            pready  = 1'b0;
            pslverr = 1'b0;
        end
        apb_info = 2'b10;
        step();
        if (rel_err) begin
            penable = 1'b1;
            pready  = 1'b1;
            pslverr = 1'b1;
        end
        #1;
        chk("release_cmd", apb_cmd, 3);
        chk("release_rd_done", rd_done, !is_wr);
        chk("release_wr_done", wr_done, is_wr);
        chk("release_xfer_err", xfer_err, exp_err);
        chk("release_grant", {30'd0, rd_grant, wr_grant}, is_wr ? 1 : 2);
        idle_apb();
        step();
        chk("after_done", {30'd0, rd_done, wr_done}, 0);
        chk("after_cmd", apb_cmd, 0);
        chk("after_busy", busy, 0);
        chk("after_grant", {30'd0, rd_grant, wr_grant}, 0);
    endtask

    initial begin
        int  rq_i, wq_i, rl, wl, rf, wc;
        bit  rd_ok_m, wr_ok_m, sel_wr, last_wr;

        vecs[0]  = '{1'b1, 3, 16, 1'b0, 0, 0, 2'b01};
        vecs[1]  = '{1'b0, 0, 16, 1'b1, 7, 7, 2'b00};
        vecs[2]  = '{1'b0, 0, 16, 1'b1, 7, 8, 2'b10};
        vecs[3]  = '{1'b1, 15, 15, 1'b0, 0, 0, 2'b00};
        vecs[4]  = '{1'b1, 15, 16, 1'b0, 0, 0, 2'b01};
        vecs[5]  = '{1'b1, 2, 16, 1'b1, 2, 16, 2'b01};
        vecs[6]  = '{1'b1, 15, 15, 1'b1, 3, 4, 2'b10};
        vecs[7]  = '{1'b0, 3, 16, 1'b0, 3, 16, 2'b00};
        vecs[8]  = '{1'b0, 0, 0, 1'b1, 0, 0, 2'b00};
        vecs[9]  = '{1'b0, 0, 0, 1'b1, 0, 1, 2'b10};
        vecs[10] = '{1'b0, 0, 0, 1'b1, 15, 16, 2'b10};
        vecs[11] = '{1'b1, 0, 0, 1'b0, 0, 16, 2'b00};

        // Reset state
        do_reset();
        chk("rst_cmd", apb_cmd, 0);
        chk("rst_grants", {30'd0, rd_grant, wr_grant}, 0);
        chk("rst_done", {30'd0, rd_done, wr_done}, 0);
        chk("rst_xfer_err", xfer_err, 0);
        chk("rst_busy", busy, 0);

        // Eligibility table, each from a fresh reset
        foreach (vecs[i]) begin
            do_reset();
            set_req(vecs[i].rq, vecs[i].rl, vecs[i].rf, vecs[i].wq, vecs[i].wl, vecs[i].wc);
            step();
            chk($sformatf("vec%0d_cmd", i), apb_cmd, vecs[i].cmd);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].cmd != 2'b00);
        end

        // Single read, full handshake
        do_reset();
        set_req(1, 3, 16, 0, 0, 0);
        step();
        rd_req = 1'b0;
        do_burst(0, 3, 16'h0000, 0, 1);

        // Tie arbitration across four bursts
        do_reset();
        set_req(1, 1, 16, 1, 1, 16);
        step();
        for (int i = 0; i < 4; i++) begin
            do_burst(i % 2 == 1, 1, 16'h0000, 0, 0);
            step();
        end
        do_reset();

        // Slave error, clean follow-up, error on the final beat in release
        set_req(1, 1, 16, 0, 0, 0);
        step();
        do_burst(0, 1, 16'h0001, 0, 0);
        step();
        do_burst(0, 1, 16'h0000, 0, 0);
        step();
        do_burst(0, 1, 16'h0000, 1, 0);
        rd_req = 1'b0;

        // Read FIFO back-pressure
        do_reset();
        set_req(1, 15, 15, 1, 3, 4);
        step();
        do_burst(1, 3, 16'h0000, 0, 0);
        wr_req = 1'b0;
        step();
        chk("bp_wait_cmd", apb_cmd, 0);
        step();
        chk("bp_wait_busy", busy, 0);
        rd_fifo_free = CNT_W'(16);
        step();
        rd_req = 1'b0;
        do_burst(0, 15, 16'h8000, 0, 0);

        // SWITCH seen while still issuing
        do_reset();
        set_req(1, 2, 16, 0, 0, 0);
        step();
        chk("collapse_issue", apb_cmd, 1);
        rd_req = 1'b0;
        apb_info = 2'b10;
        step();
        chk("collapse_cmd", apb_cmd, 3);
        chk("collapse_done", rd_done, 1);
        chk("collapse_err", xfer_err, 0);
        apb_info = 2'b00;
        step();
        chk("collapse_after", {30'd0, apb_cmd, rd_done}, 0);

        // Reset in the middle of a burst
        do_reset();
        set_req(0, 0, 0, 1, 2, 16);
        step();
        apb_info = 2'b01;
        step();
        chk("mid_run_busy", busy, 1);
        chk("mid_run_grant", wr_grant, 1);
        apb_info = 2'b11;
        step();
        chk("mid_info11_ignored", busy, 1);
        wr_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd", apb_cmd, 0);
        chk("mid_rst_grants", {30'd0, rd_grant, wr_grant}, 0);
        chk("mid_rst_busy", busy, 0);
        apb_info = 2'b10;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_no_done", {30'd0, rd_done, wr_done}, 0);
        end
        idle_apb();

        // Randomized bursts against a transaction-level model
        do_reset();
        last_wr = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rq_i = int'($urandom % 2);
            wq_i = int'($urandom % 2);
            rl = int'($urandom % 16);
            wl = int'($urandom % 16);
            rf = rl + int'($urandom % 3) - 1;
            wc = wl + int'($urandom % 3) - 1;
            if (rf < 0) rf = 0;
            if (rf > 16) rf = 16;
            if (wc < 0) wc = 0;
            if (wc > 16) wc = 16;
            rd_ok_m = (rq_i == 1) && (rf >= rl + 1);
            wr_ok_m = (wq_i == 1) && (wc >= wl + 1);
            set_req(1'(rq_i), rl, rf, 1'(wq_i), wl, wc);
            if (!rd_ok_m && !wr_ok_m) begin
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("rand_idle_cmd", apb_cmd, 0);
                    chk("rand_idle_busy", busy, 0);
                end
            end else begin
                sel_wr = (rd_ok_m && wr_ok_m) ? !last_wr : wr_ok_m;
                step();
                do_burst(sel_wr, sel_wr ? wl : rl, 16'($urandom & $urandom),
                         ($urandom % 4) == 0, int'($urandom % 3));
                last_wr = sel_wr;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
